// File: rtl/mem_arbiter_if.sv
// Handshake bundle between the IF/MEM pipeline stages, the arbiter and the
// ram_controller request/done bus.
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic [DATA_W-1:0] if_rdata;
  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_done;
  logic [DATA_W-1:0] mem_rdata;
  logic              stall_if;
  logic              bus_err;
  logic              ram_req;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_done;
  logic [DATA_W-1:0] ram_rdata;

  // Arbiter view.
  modport slave (
    input  if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata, ram_done, ram_rdata,
    output if_done, if_rdata, mem_done, mem_rdata, stall_if, bus_err,
           ram_req, ram_we, ram_addr, ram_wdata
  );

  // Requester / RAM-controller view.
  modport master (
    output if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata, ram_done, ram_rdata,
    input  if_done, if_rdata, mem_done, mem_rdata, stall_if, bus_err,
           ram_req, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares the single RAM request/done path between instruction fetch and the MEM
// stage: one grant at a time, timeout abort, per-requester read data registers.
module mem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int TIMEOUT    = 255,
  parameter int TO_W       = 8,
  parameter int STARVE_MAX = 2
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM, DONE} state_t;

  state_t            state, state_d;
  logic [TO_W-1:0]   to_cnt;
  logic [SW-1:0]     starve_cnt;
  logic              ram_req_q, ram_we_q, if_done_q, mem_done_q, bus_err_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_wdata_q, if_rdata_q, mem_rdata_q;

  logic mem_any, starved, grant_if, grant_mem, busy, timed_out, finish;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    mem_any   = bus.mem_rd | bus.mem_wr;
    starved   = (starve_cnt == SW'(STARVE_MAX));
    grant_if  = 1'b0;
    grant_mem = 1'b0;
    busy      = (state == BUSY_IF) || (state == BUSY_MEM);
    timed_out = busy && !bus.ram_done && (to_cnt == TO_W'(TIMEOUT - 1));
    finish    = busy && (bus.ram_done || timed_out);
    state_d   = state;
    unique case (state)
      IDLE: begin
        // IF only overtakes a pending MEM request once it has lost STARVE_MAX times.
        grant_if  = bus.if_req && (!mem_any || starved);
        grant_mem = mem_any && !grant_if;
        if (grant_if)       state_d = BUSY_IF;
        else if (grant_mem) state_d = BUSY_MEM;
      end
      BUSY_IF, BUSY_MEM: if (finish) state_d = DONE;
      DONE:              state_d = IDLE;
      default:           state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments make every flop update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt      <= '0;
      starve_cnt  <= '0;
      ram_req_q   <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      bus_err_q   <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      ram_req_q  <= (state_d == BUSY_IF) || (state_d == BUSY_MEM);
      if_done_q  <= finish && (state == BUSY_IF);
      mem_done_q <= finish && (state == BUSY_MEM);
      bus_err_q  <= timed_out;

      if (busy && !finish) to_cnt <= to_cnt + 1'b1;
      else                 to_cnt <= '0;

      if (grant_if) begin
        ram_addr_q <= bus.if_addr;
        ram_we_q   <= 1'b0;
        starve_cnt <= '0;
      end else if (grant_mem) begin
        // A simultaneous read+write is carried out as the write alone.
        ram_addr_q  <= bus.mem_addr;
        ram_wdata_q <= bus.mem_wdata;
        ram_we_q    <= bus.mem_wr;
        if (bus.if_req && !starved) starve_cnt <= starve_cnt + 1'b1;
      end

      if (finish && (state == BUSY_IF))
        if_rdata_q <= timed_out ? '1 : bus.ram_rdata;
      if (finish && (state == BUSY_MEM) && !ram_we_q)
        mem_rdata_q <= timed_out ? '1 : bus.ram_rdata;
    end
  end

  assign bus.ram_req   = ram_req_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.if_done   = if_done_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.mem_done  = mem_done_q;
  assign bus.mem_rdata = mem_rdata_q;
  assign bus.bus_err   = bus_err_q;
  assign bus.stall_if  = bus.if_req & ~if_done_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests push expected RAM accesses
// and completions; negedge monitors pop and compare as the DUT presents them.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(8), .TO_W(8), .STARVE_MAX(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct { logic we; logic [15:0] addr; logic [15:0] wdata; } ram_t;
  typedef struct { logic side; logic [15:0] rdata; logic err; } done_t;  // side 1 = MEM

  ram_t  ram_q[$];
  done_t done_q[$];
  ram_t  cur_ram;
  logic [15:0] ram_img [logic [15:0]];

  int n_tests = 0;
  int n_fail  = 0;
  int ram_lat = 1;
  int rsp_cnt = 0;
  int req_len = 0;
  int last_req_len = 0;
  logic prev_req = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  task automatic exp_ram(input logic we, input logic [15:0] addr, input logic [15:0] wdata);
    ram_t r;
    r.we = we; r.addr = addr; r.wdata = wdata;
    ram_q.push_back(r);
  endtask

  task automatic exp_done(input logic side, input logic [15:0] rdata, input logic err);
    done_t d;
    d.side = side; d.rdata = rdata; d.err = err;
    done_q.push_back(d);
  endtask

  // RAM controller model: raises ram_done ram_lat cycles after ram_req rises (0 = never).
  initial begin
    bus.ram_done  = 1'b0;
    bus.ram_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (bus.ram_req && !bus.ram_done) begin
        rsp_cnt++;
        if (ram_lat != 0 && rsp_cnt == ram_lat) begin
          bus.ram_done = 1'b1;
          if (bus.ram_we) ram_img[bus.ram_addr] = bus.ram_wdata;
          else bus.ram_rdata = ram_img.exists(bus.ram_addr) ? ram_img[bus.ram_addr] : 16'h0000;
        end
      end else begin
        rsp_cnt = 0;
        bus.ram_done = 1'b0;
      end
    end
  end

  // Monitor: RAM-side requests and requester completions.
  always @(negedge clk) begin
    if (!rst) begin
      prev_req = 1'b0;
      req_len  = 0;
    end else begin
      if (bus.ram_req) begin
        if (!prev_req) begin
          if (ram_q.size() == 0) fail("ram_unexpected_request");
          else begin
            cur_ram = ram_q.pop_front();
            check("ram_we", bus.ram_we, cur_ram.we);
            check("ram_addr", bus.ram_addr, cur_ram.addr);
            if (cur_ram.we) check("ram_wdata", bus.ram_wdata, cur_ram.wdata);
          end
        end else if (bus.ram_addr !== cur_ram.addr || bus.ram_we !== cur_ram.we) begin
          fail("ram_not_stable");
        end
        req_len++;
      end else if (prev_req) begin
        last_req_len = req_len;
        req_len = 0;
      end
      prev_req = bus.ram_req;

      if (bus.if_done && bus.mem_done) fail("both_done_same_cycle");
      else if (bus.if_done || bus.mem_done) begin
        if (done_q.size() == 0) fail("unexpected_done");
        else begin
          done_t d;
          d = done_q.pop_front();
          check("done_side", bus.mem_done, d.side);
          check("done_rdata", d.side ? bus.mem_rdata : bus.if_rdata, d.rdata);
          check("done_bus_err", bus.bus_err, d.err);
        end
      end
    end
  end

  task automatic wait_if(output int waited);
    bit stall_ok = 1'b1;
    bit got = 1'b0;
    waited = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      waited++;
      if (bus.if_done) got = 1'b1;
      else if (!bus.stall_if) stall_ok = 1'b0;
    end
    check("stall_if_while_pending", stall_ok, 1);
    if (got) check("stall_if_at_done", bus.stall_if, 0);
    else fail("if_done_timeout");
    bus.if_req = 1'b0;
  endtask

  task automatic do_if(input logic [15:0] addr, output int waited);
    bus.if_addr = addr;
    bus.if_req  = 1'b1;
    wait_if(waited);
  endtask

  task automatic wait_mem(output int waited);
    bit got = 1'b0;
    waited = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      waited++;
      if (bus.mem_done) got = 1'b1;
    end
    if (!got) fail("mem_done_timeout");
    bus.mem_rd = 1'b0;
    bus.mem_wr = 1'b0;
  endtask

  task automatic do_mem(input logic rd, input logic wr, input logic [15:0] addr,
                        input logic [15:0] wdata, output int waited);
    bus.mem_addr  = addr;
    bus.mem_wdata = wdata;
    bus.mem_rd    = rd;
    bus.mem_wr    = wr;
    wait_mem(waited);
  endtask

  task automatic idle_gap();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w_if, w_mem;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.mem_rd = 1'b0; bus.mem_wr = 1'b0; bus.mem_addr = '0; bus.mem_wdata = '0;
    ram_img[16'h0010] = 16'h4A21; ram_img[16'h0020] = 16'h1234;
    ram_img[16'h0100] = 16'h0A0A; ram_img[16'h0101] = 16'h0B0B;
    ram_img[16'h0102] = 16'h0C0C; ram_img[16'h0030] = 16'h7777;
    ram_img[16'h0040] = 16'hC3C3; ram_img[16'h0200] = 16'h5555;

    repeat (3) @(negedge clk);
    check("reset_ram_req", bus.ram_req, 0);
    check("reset_if_done", bus.if_done, 0);
    check("reset_mem_done", bus.mem_done, 0);
    check("reset_bus_err", bus.bus_err, 0);
    check("reset_if_rdata", bus.if_rdata, 0);
    check("reset_mem_rdata", bus.mem_rdata, 0);
    check("reset_stall_if", bus.stall_if, 0);
    rst = 1'b1;
    idle_gap();

    // T1: single IF fetch, ram_done two cycles after ram_req.
    ram_lat = 2;
    exp_ram(1'b0, 16'h0010, 16'h0000);
    exp_done(1'b0, 16'h4A21, 1'b0);
    do_if(16'h0010, w_if);
    check("t1_if_latency", w_if, 3);
    idle_gap();

    // T2: MEM write and IF read in the same cycle; MEM goes first.
    ram_lat = 1;
    exp_ram(1'b1, 16'h8003, 16'hBEEF);
    exp_ram(1'b0, 16'h0020, 16'h0000);
    exp_done(1'b1, 16'h0000, 1'b0);
    exp_done(1'b0, 16'h1234, 1'b0);
    fork
      do_mem(1'b0, 1'b1, 16'h8003, 16'hBEEF, w_mem);
      do_if(16'h0020, w_if);
    join
    check("t2_mem_min_latency", w_mem, 2);
    idle_gap();

    // T3: IF held against repeated MEM reads; IF forced on the third arbitration.
    exp_ram(1'b0, 16'h0100, 16'h0000); exp_done(1'b1, 16'h0A0A, 1'b0);
    exp_ram(1'b0, 16'h0101, 16'h0000); exp_done(1'b1, 16'h0B0B, 1'b0);
    exp_ram(1'b0, 16'h0030, 16'h0000); exp_done(1'b0, 16'h7777, 1'b0);
    exp_ram(1'b0, 16'h0102, 16'h0000); exp_done(1'b1, 16'h0C0C, 1'b0);
    fork
      do_if(16'h0030, w_if);
      begin
        do_mem(1'b1, 1'b0, 16'h0100, 16'h0000, w_mem);
        do_mem(1'b1, 1'b0, 16'h0101, 16'h0000, w_mem);
        do_mem(1'b1, 1'b0, 16'h0102, 16'h0000, w_mem);
      end
    join
    idle_gap();

    // T4: RAM never answers; abort after TIMEOUT=8 cycles with bus_err.
    ram_lat = 0;
    exp_ram(1'b0, 16'h0040, 16'h0000);
    exp_done(1'b1, 16'hFFFF, 1'b1);
    do_mem(1'b1, 1'b0, 16'h0040, 16'h0000, w_mem);
    @(posedge clk);
    check("t4_ram_req_cycles", last_req_len, 8);
    idle_gap();

    // T5: reset in the middle of a MEM access, then restart.
    exp_ram(1'b0, 16'h0200, 16'h0000);
    exp_ram(1'b0, 16'h0200, 16'h0000);
    bus.mem_addr = 16'h0200;
    bus.mem_rd   = 1'b1;
    repeat (3) @(negedge clk);
    check("t5_busy_before_reset", bus.ram_req, 1);
    #2 rst = 1'b0;
    #1;
    check("t5_ram_req_dropped", bus.ram_req, 0);
    check("t5_mem_rdata_cleared", bus.mem_rdata, 0);
    repeat (2) begin
      @(negedge clk);
      check("t5_no_done_in_reset", bus.mem_done, 0);
    end
    ram_lat = 2;
    exp_done(1'b1, 16'h5555, 1'b0);
    rst = 1'b1;
    wait_mem(w_mem);
    check("t5_restart_latency", w_mem, 3);
    idle_gap();

    // T6: read and write together act as one write; mem_rdata untouched.
    ram_lat = 1;
    exp_ram(1'b1, 16'h0041, 16'h9ABC);
    exp_done(1'b1, 16'h5555, 1'b0);
    do_mem(1'b1, 1'b1, 16'h0041, 16'h9ABC, w_mem);
    idle_gap();
    exp_ram(1'b0, 16'h0041, 16'h0000);
    exp_done(1'b1, 16'h9ABC, 1'b0);
    do_mem(1'b1, 1'b0, 16'h0041, 16'h0000, w_mem);
    idle_gap();

    check("ram_queue_drained", ram_q.size(), 0);
    check("done_queue_drained", done_q.size(), 0);
    check("idle_ram_req", bus.ram_req, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
